// File: rtl/mips32_prog_loader_pkg.sv
// Shared types and constants for the MIPS32 boot-time program loader.
// LOADER_CHECKSUM_EN adds the trailing checksum state.
package mips32_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } ld_state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_W     = 8;

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input and core-memory write port of the program loader.
// master = host/memory side, slave = the loader.
interface mips32_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (output in_data, in_valid,
                  input  in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input  in_data, in_valid,
                  output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/mips32_word_packer.sv
// Packs big-endian bytes into 32-bit words. The last byte is taken straight
// from the stream so the word and word_done are ready on the same edge.
module mips32_word_packer
  import mips32_loader_pkg::*;
(
  input  logic        clk1,
  input  logic        clr,
  input  logic [7:0]  din,
  input  logic        stb,
  output logic [31:0] word,
  output logic        word_done
);
  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0] idx;
  logic [23:0]      sh;

  assign word      = {sh, din};
  assign word_done = stb && (idx == IDX_W'(WORD_BYTES - 1));

  always_ff @(posedge clk1) begin
    if (clr) begin
      idx <= '0;
      sh  <= '0;
    end else if (stb) begin
      idx <= idx + IDX_W'(1);
      sh  <= {sh[15:0], din};
    end
  end
endmodule

// File: rtl/mips32_prog_loader.sv
// Boot loader: length-prefixed byte frame -> 32-bit writes from word 0, then
// releases the core. Optional trailing checksum under LOADER_CHECKSUM_EN.
module mips32_prog_loader
  import mips32_loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 start,
  mips32_prog_loader_if.slave  bus,
  output logic                 busy,
  output logic                 core_run,
  output logic                 err
);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  ld_state_t         state;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [ADDR_W-1:0] wcnt;
  logic              xfer, arm, last_word, pk_done;
  logic [15:0]       n_hdr;
  logic [31:0]       pk_word;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign arm       = start && (state inside {S_IDLE, S_DONE, S_ERROR});
  assign n_hdr     = {len_hi, bus.in_data};
  assign last_word = (16'(wcnt) == len - 16'd1);

  mips32_word_packer u_pack (
    .clk1      (clk1),
    .clr       (rst || arm),
    .din       (bus.in_data),
    .stb       (xfer && state == S_DATA),
    .word      (pk_word),
    .word_done (pk_done)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum;
  logic              csum_ok;
  assign csum_ok = (CSUM_W'(csum + bus.in_data) == '0);
`endif

  always_ff @(posedge clk1) begin
    if (rst) begin
      state         <= S_IDLE;
      len_hi        <= '0;
      len           <= '0;
      wcnt          <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      busy          <= 1'b0;
      core_run      <= 1'b0;
      err           <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      // Status follows the state one edge late so core_run never overlaps the last write.
      core_run   <= (state == S_DONE) && !start;
      err        <= (state == S_ERROR) && !start;
      if (pk_done) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= wcnt;
        bus.mem_wdata <= pk_word;
      end
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_LEN_HI;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            wcnt         <= '0;
            len_hi       <= '0;
            len          <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= bus.in_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len <= n_hdr;
            if (n_hdr == 16'd0) begin
              state        <= S_DONE;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
            end else if ({16'd0, n_hdr} > DEPTH_U) begin
              state        <= S_ERROR;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum + bus.in_data;
`endif
            if (pk_done) begin
              if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                state <= S_CSUM;
`else
                state        <= S_DONE;
                bus.in_ready <= 1'b0;
                busy         <= 1'b0;
`endif
              end else begin
                wcnt <= wcnt + ADDR_W'(1);
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            state        <= csum_ok ? S_DONE : S_ERROR;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
          end
        end
`endif
        default: begin
          state        <= S_IDLE;
          bus.in_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end
endmodule
